// File: rtl/fdiv_mant_divider.sv
// Radix-2 restoring mantissa divider for the FDiv unit. It produces one quotient bit per cycle.
// It outputs a QW-bit raw quotient, a sticky bit, a divide-by-zero flag and the passthrough tag.
module fdiv_mant_divider #(
  parameter int MW = 24,
  parameter int QW = 32,
  parameter int TW = 10
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] a_man,
  input  logic [MW-1:0] b_man,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] q,
  output logic          sticky,
  output logic          dz,
  output logic [TW-1:0] out_tag
);

  localparam int KW = $clog2(QW) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(QW - 1);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [MW:0]   r_rem;
  logic [MW-1:0] r_b;
  logic [QW-1:0] r_q;
  logic [KW-1:0] r_k;
  logic          r_sticky;
  logic          r_dz;
  logic          r_out_valid;
  logic [TW-1:0] r_tag;

  logic [MW+1:0] w_t;
  logic          w_ge;
  logic [MW:0]   w_rem_next;

  // The top bit of w_t is the sign of the trial subtraction.
  // The remainder stays below 2B, so no wider guard is needed.
  assign w_t        = {1'b0, r_rem} - {2'b00, r_b};
  assign w_ge       = ~w_t[MW+1];
  assign w_rem_next = w_ge ? w_t[MW:0] : r_rem;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign q         = r_q;
  assign sticky    = r_sticky;
  assign dz        = r_dz;
  assign out_tag   = r_tag;

  // Control FSM and datapath registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= {(MW+1){1'b0}};
      r_b         <= {MW{1'b0}};
      r_q         <= {QW{1'b0}};
      r_k         <= {KW{1'b0}};
      r_sticky    <= 1'b0;
      r_dz        <= 1'b0;
      r_out_valid <= 1'b0;
      r_tag       <= {TW{1'b0}};
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_k         <= {KW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_b      <= b_man;
            r_tag    <= in_tag;
            r_rem    <= {1'b0, a_man};
            r_q      <= {QW{1'b0}};
            r_k      <= {KW{1'b0}};
            r_sticky <= 1'b0;
            if (b_man == {MW{1'b0}}) begin
              r_dz        <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_dz    <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Quotient bits shift in from the LSB, so the first bit ends at q[QW-1].
          r_q   <= {r_q[QW-2:0], w_ge};
          r_rem <= {w_rem_next[MW-1:0], 1'b0};
          r_k   <= r_k + K_ONE;
          if (r_k == K_LAST) begin
            r_sticky    <= |w_rem_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
